dds_sweep_ctrl: RTL and testbench
=================================

# dds_sweep_ctrl

Frequency-sweep sequencer for the DDS phase-accumulator cores. It drives the DDS frequency control word M (`frq_w`) through a programmable linear sweep from `f_start` to `f_stop`, moving by `f_step` and holding each point for `dwell` clock cycles. Sweeps run up or down, as a single pass or continuously. It sits between the front-panel/configuration logic and the `FRQ_W` input of the 14-bit DDS, in the 10 MHz clock domain.

## Interface
- `FW`, 12: frequency-word width; must match the DDS `FRQ_W` width.
- `DW`, 16: dwell-counter width.
- `clk`  in  1  system clock (10 MHz).
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle request to begin a sweep; sampled only in IDLE.
- `stop`  in  1  one-cycle abort request; honoured in any state.
- `mode`  in  1  0 = single pass, 1 = continuous (restart at `f_start` after `f_stop`).
- `f_start`  in  FW  first frequency word.
- `f_stop`  in  FW  last frequency word; `f_stop < f_start` selects a downward sweep.
- `f_step`  in  FW  step magnitude (unsigned).
- `dwell`  in  DW  cycles each point is held; 0 is treated as 1.
- `frq_w`  out  FW  registered frequency word to the DDS.
- `busy`  out  1  high while a sweep is active.
- `step_tick`  out  1  one-cycle pulse in each cycle where `frq_w` takes a new sweep value, including the first.
- `done`  out  1  one-cycle pulse when a single-pass sweep completes.

## Operation
- States: IDLE, DWELL, STEP.
- **Start:** In IDLE, `start` latches `f_start`, `f_stop`, `f_step`, `dwell` and `mode` into shadow registers. The block then loads `frq_w <= f_start` and enters DWELL with the counter set to max(`dwell`,1). Input changes during a sweep have no effect until the next start.
- **Direction:** `dir_up = (f_stop >= f_start)`, fixed at start.
- **DWELL:** The counter decrements every cycle. On the cycle the counter reaches 1, the block goes to STEP, or ends the point if it is the last one.
- **STEP:** The next value is computed in FW+1 bits, so there is no wrap-around.
  - Upward: `nxt = frq_w + f_step`; if `nxt >= f_stop`, then `nxt = f_stop`.
  - Downward: `nxt = frq_w - f_step`; if the result is below `f_stop`, it clamps to `f_stop`.
  - `frq_w <= nxt`, `step_tick = 1`, counter reloads, and the state returns to DWELL.
  - STEP costs no extra cycle: it is the transition cycle in which the new value is registered.
- **Last point:** The last point is the dwell on `frq_w == f_stop`. When it expires:
  - Single pass: go to IDLE, pulse `done`, `frq_w` holds `f_stop`.
  - Continuous: `frq_w <= f_start`, `step_tick = 1`, new pass, no `done`.
- **Degenerate sweeps:** `f_step == 0` or `f_start == f_stop` gives a single-point sweep: one dwell at `f_start`, then end as above.
- **Stop:** From any non-IDLE state, go to IDLE on the next edge. `frq_w` holds its current value, `busy` drops, and no `done` pulse is produced.
- **Simultaneous `start` and `stop`:** `stop` wins; the block stays or returns to IDLE.
- **`start` while busy:** ignored.

## Timing
- **Reset values:** `frq_w = 0`, `busy = 0`, `step_tick = 0`, `done = 0`, state IDLE, all shadow registers 0.
- **Start latency:** `start` high at edge k puts `f_start` on `frq_w`, with `busy = 1` and `step_tick = 1`, from cycle k+1.
- **Hold time:** Each point is held exactly max(`dwell`,1) cycles. Consecutive values are back-to-back with no gap cycle.
- **Single-pass end:** In the cycle after the last dwell cycle, `done = 1` and `busy = 0`.
- **Stop latency:** `busy = 0` one cycle after `stop`.
- **Reset mid-sweep:** Asynchronous `rst_n` low forces all reset values immediately. The sweep resumes only on a new `start`.
- **Outputs:** All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- **Up sweep, single pass:** `f_start = 100`, `f_step = 50`, `f_stop = 200`, `dwell = 4`, `mode = 0`, start at cycle 0.
  - `frq_w` = 100 for cycles 1–4, 150 for 5–8, 200 for 9–12.
  - `done = 1`, `busy = 0` at cycle 13.
  - `step_tick` pulses at cycles 1, 5 and 9.
- **Clamped down sweep:** `f_start = 300`, `f_step = 120`, `f_stop = 50`, `dwell = 2` gives 300, 180, 60, 50 (clamped), each held 2 cycles, then `done`.
- **Overflow guard:** `f_start = 4000`, `f_step = 200`, `f_stop = 4095`, `FW = 12` gives 4000, then 4095. There must be no wrap to a small value.
- **Continuous mode:** `f_start = 10`, `f_step = 10`, `f_stop = 30`, `dwell = 1`, `mode = 1` gives 10, 20, 30, 10, 20… every cycle. `done` never pulses and `busy` stays 1.
- **Stop handling:** `stop` at cycle 6 of the first scenario gives `busy = 0` at cycle 7, `frq_w` holds 150, and no `done`.
  - `start` and `stop` in the same cycle from IDLE: the block stays idle.
  - `start` while busy: ignored.
- **Degenerate and reset cases:**
  - `dwell = 0` behaves like `dwell = 1`.
  - `f_step = 0` gives one point at `f_start`, then `done`.
  - `rst_n` pulsed low mid-sweep gives `frq_w = 0` and `busy = 0` immediately.

Source files
------------

// File: rtl/dds_sweep_ctrl.sv
// Linear frequency-sweep sequencer driving the DDS frequency control word.
// Each point is held max(dwell,1) cycles, and all outputs are registered.
`timescale 1ns/1ps

module dds_sweep_ctrl #(
    parameter int FW = 12,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          stop,
    input  logic          mode,
    input  logic [FW-1:0] f_start,
    input  logic [FW-1:0] f_stop,
    input  logic [FW-1:0] f_step,
    input  logic [DW-1:0] dwell,
    output logic [FW-1:0] frq_w,
    output logic          busy,
    output logic          step_tick,
    output logic          done
);

    // STEP marks the first cycle of a freshly loaded point; it counts down like DWELL.
    typedef enum logic [1:0] {IDLE, DWELL, STEP} state_t;

    state_t        state, state_nxt;
    logic [FW-1:0] start_s, stop_s, step_s;
    logic [DW-1:0] dwell_s, cnt, cnt_nxt;
    logic          mode_s, dir_up_s;
    logic          latch;
    logic [FW-1:0] frq_nxt, nxt_val;
    logic          busy_nxt, tick_nxt, done_nxt;
    logic [FW:0]   sum, diff;
    logic          last_pt;
    logic [DW-1:0] dwell_eff;

    assign dwell_eff = (dwell == '0) ? DW'(1) : dwell;
    assign sum       = {1'b0, frq_w} + {1'b0, step_s};
    assign diff      = {1'b0, frq_w} - {1'b0, step_s};
    assign last_pt   = (frq_w == stop_s) || (step_s == '0);

    // Extra MSB catches both overflow above 2^FW and underflow below zero.
    always_comb begin
        nxt_val = stop_s;
        if (dir_up_s) begin
            if (sum < {1'b0, stop_s})
                nxt_val = sum[FW-1:0];
        end else begin
            if (!diff[FW] && (diff[FW-1:0] > stop_s))
                nxt_val = diff[FW-1:0];
        end
    end

    always_comb begin
        state_nxt = state;
        frq_nxt   = frq_w;
        cnt_nxt   = cnt;
        tick_nxt  = 1'b0;
        done_nxt  = 1'b0;
        latch     = 1'b0;
        case (state)
            IDLE: begin
                if (start && !stop) begin
                    latch     = 1'b1;
                    frq_nxt   = f_start;
                    cnt_nxt   = dwell_eff;
                    tick_nxt  = 1'b1;
                    state_nxt = STEP;
                end
            end
            DWELL, STEP: begin
                if (stop) begin
                    state_nxt = IDLE;
                end else if (cnt <= DW'(1)) begin
                    if (last_pt && !mode_s) begin
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        frq_nxt   = last_pt ? start_s : nxt_val;
                        cnt_nxt   = dwell_s;
                        tick_nxt  = 1'b1;
                        state_nxt = STEP;
                    end
                end else begin
                    cnt_nxt   = cnt - DW'(1);
                    state_nxt = DWELL;
                end
            end
            default: state_nxt = IDLE;
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            frq_w     <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
            step_tick <= 1'b0;
            done      <= 1'b0;
            start_s   <= '0;
            stop_s    <= '0;
            step_s    <= '0;
            dwell_s   <= '0;
            mode_s    <= 1'b0;
            dir_up_s  <= 1'b0;
        end else begin
            state     <= state_nxt;
            frq_w     <= frq_nxt;
            cnt       <= cnt_nxt;
            busy      <= busy_nxt;
            step_tick <= tick_nxt;
            done      <= done_nxt;
            if (latch) begin
                start_s  <= f_start;
                stop_s   <= f_stop;
                step_s   <= f_step;
                dwell_s  <= dwell_eff;
                mode_s   <= mode;
                dir_up_s <= (f_stop >= f_start);
            end
        end
    end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Bench for dds_sweep_ctrl: per-cycle comparison against a point-list sweep model.
`timescale 1ns/1ps

module tb_dds_sweep_ctrl;
    localparam int FW = 12;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          mode = 1'b0;
    logic [FW-1:0] f_start = '0;
    logic [FW-1:0] f_stop = '0;
    logic [FW-1:0] f_step = '0;
    logic [DW-1:0] dwell = '0;
    logic [FW-1:0] frq_w;
    logic          busy, step_tick, done;

    dds_sweep_ctrl #(.FW(FW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode),
        .f_start(f_start), .f_stop(f_stop), .f_step(f_step), .dwell(dwell),
        .frq_w(frq_w), .busy(busy), .step_tick(step_tick), .done(done)
    );

    always #50 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model: the sweep is the list of points visited, each held m_d cycles.
    int    pts[$];
    int    m_d, m_mode, m_stop_n;
    int    m_n = 0;
    bit    m_active = 1'b0;
    string m_tag = "";

    logic [FW-1:0] tr_frq[0:63];
    logic          tr_busy[0:63];
    logic          tr_tick[0:63];
    logic          tr_done[0:63];

    task automatic model_at(input int n, output int efrq, output int ebusy,
                            output int etick, output int edone);
        int eff, len, total, idx;
        eff   = (m_stop_n > 0 && n > m_stop_n) ? m_stop_n : n;
        len   = pts.size();
        total = len * m_d;
        if (m_mode != 0 || eff <= total) begin
            idx   = ((eff - 1) / m_d) % len;
            efrq  = pts[idx];
            ebusy = 1;
            etick = ((eff - 1) % m_d == 0) ? 1 : 0;
            edone = 0;
        end else begin
            efrq  = pts[len-1];
            ebusy = 0;
            etick = 0;
            edone = (eff == total + 1) ? 1 : 0;
        end
        if (eff != n) begin
            ebusy = 0;
            etick = 0;
            edone = 0;
        end
    endtask

    always @(posedge clk) begin
        int efrq, ebusy, etick, edone;
        #1;
        if (m_active) begin
            m_n++;
            model_at(m_n, efrq, ebusy, etick, edone);
            check($sformatf("%s c%0d frq_w", m_tag, m_n), 32'(frq_w), efrq);
            check($sformatf("%s c%0d busy", m_tag, m_n), 32'(busy), ebusy);
            check($sformatf("%s c%0d step_tick", m_tag, m_n), 32'(step_tick), etick);
            check($sformatf("%s c%0d done", m_tag, m_n), 32'(done), edone);
            if (m_n < 64) begin
                tr_frq[m_n]  = frq_w;
                tr_busy[m_n] = busy;
                tr_tick[m_n] = step_tick;
                tr_done[m_n] = done;
            end
        end
    end

    task automatic run(input string tag, input int fs, input int fe, input int fst,
                       input int dw, input int md, input int ncyc, input int stop_n,
                       input int restart_n);
        int p;
        @(negedge clk);
        f_start = fs[FW-1:0];
        f_stop  = fe[FW-1:0];
        f_step  = fst[FW-1:0];
        dwell   = dw[DW-1:0];
        mode    = md[0];
        start   = 1'b1;
        pts.delete();
        p = fs;
        forever begin
            pts.push_back(p);
            if (p == fe || fst == 0) break;
            if (fe >= fs) p = (p + fst > fe) ? fe : p + fst;
            else          p = (p - fst < fe) ? fe : p - fst;
        end
        m_d      = (dw == 0) ? 1 : dw;
        m_mode   = md;
        m_stop_n = stop_n;
        m_tag    = tag;
        m_n      = 0;
        m_active = 1'b1;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            start   = (c == restart_n);
            f_start = (c == restart_n) ? 12'd999 : fs[FW-1:0];
            stop    = (c == stop_n);
        end
        m_active = 1'b0;
        start    = 1'b0;
        stop     = 1'b0;
    endtask

    initial begin
        #10;
        check("reset frq_w", 32'(frq_w), 0);
        check("reset busy", 32'(busy), 0);
        check("reset step_tick", 32'(step_tick), 0);
        check("reset done", 32'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Up sweep with an ignored start (new f_start) while busy.
        run("up", 100, 200, 50, 4, 0, 15, 0, 3);
        check("up lit c1", 32'(tr_frq[1]), 100);
        check("up lit c4", 32'(tr_frq[4]), 100);
        check("up lit c5", 32'(tr_frq[5]), 150);
        check("up lit c9", 32'(tr_frq[9]), 200);
        check("up lit c12", 32'(tr_frq[12]), 200);
        check("up lit tick5", 32'(tr_tick[5]), 1);
        check("up lit done13", 32'(tr_done[13]), 1);
        check("up lit busy13", 32'(tr_busy[13]), 0);

        run("down", 300, 50, 120, 2, 0, 11, 0, 0);
        check("down lit c5", 32'(tr_frq[5]), 60);
        check("down lit c7", 32'(tr_frq[7]), 50);
        check("down lit done9", 32'(tr_done[9]), 1);

        run("ovf", 4000, 4095, 200, 3, 0, 8, 0, 0);
        check("ovf lit c4", 32'(tr_frq[4]), 4095);

        run("cont", 10, 30, 10, 1, 1, 11, 9, 0);
        check("cont lit c4", 32'(tr_frq[4]), 10);
        check("cont lit c9", 32'(tr_busy[9]), 1);

        run("stop", 100, 200, 50, 4, 0, 10, 6, 0);
        check("stop lit busy7", 32'(tr_busy[7]), 0);
        check("stop lit frq7", 32'(tr_frq[7]), 150);

        run("dw0", 5, 8, 3, 0, 0, 5, 0, 0);
        check("dw0 lit c2", 32'(tr_frq[2]), 8);

        run("step0", 7, 100, 0, 2, 0, 5, 0, 0);
        check("step0 lit done3", 32'(tr_done[3]), 1);

        // Asynchronous reset in the middle of a sweep.
        run("rst", 100, 200, 50, 4, 0, 6, 0, 0);
        check("rst pre frq_w", 32'(frq_w), 150);
        check("rst pre busy", 32'(busy), 1);
        #10;
        rst_n = 1'b0;
        #1;
        check("rst async frq_w", 32'(frq_w), 0);
        check("rst async busy", 32'(busy), 0);
        check("rst async step_tick", 32'(step_tick), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rst after busy", 32'(busy), 0);
        check("rst after frq_w", 32'(frq_w), 0);

        // start and stop together from IDLE: stays idle.
        @(negedge clk);
        f_start = 12'd77;
        start   = 1'b1;
        stop    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        check("ss busy c1", 32'(busy), 0);
        check("ss tick c1", 32'(step_tick), 0);
        repeat (2) @(negedge clk);
        check("ss busy c3", 32'(busy), 0);
        check("ss frq_w", 32'(frq_w), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
